// File: rtl/alu_seq_ctrl.sv
// Sequencer for a 16-lane vector ALU: read two source registers, execute, write result back.
// Optional macro ALU_HI_WB_EN adds a second writeback of the hi words to rd+1.
module alu_seq_ctrl #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [REG_AW-1:0] cmd_rd,
    output logic              rf_rd_en,
    output logic [REG_AW-1:0] rf_rd_addr_a,
    output logic [REG_AW-1:0] rf_rd_addr_b,
    output logic              alu_op,
    output logic              res_load,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic              rf_wr_sel,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ops_done
);

`ifdef ALU_HI_WB_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB_LO, S_WB_HI} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB_LO} state_t;
`endif

    state_t            state, state_n;
    logic              op_q;
    logic [REG_AW-1:0] ra_q, rb_q, rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            ops_done <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && cmd_valid) begin
                op_q <= cmd_op;
                ra_q <= cmd_ra;
                rb_q <= cmd_rb;
                rd_q <= cmd_rd;
            end
            if (done)
                ops_done <= ops_done + 1'b1;
        end
    end

    // Latched command fields drive the addresses and op directly, so they are never X
    // and alu_op keeps the last op while idle.
    assign rf_rd_addr_a = ra_q;
    assign rf_rd_addr_b = rb_q;
    assign alu_op       = op_q;
    assign busy         = (state != S_IDLE);

    always_comb begin
        state_n    = state;
        cmd_ready  = 1'b0;
        rf_rd_en   = 1'b0;
        res_load   = 1'b0;
        rf_wr_en   = 1'b0;
        rf_wr_sel  = 1'b0;
        rf_wr_addr = rd_q;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_n = S_READ;
            end
            S_READ: begin
                rf_rd_en = 1'b1;
                state_n  = S_EXEC;
            end
            S_EXEC: begin
                res_load = 1'b1;
                state_n  = S_WB_LO;
            end
            S_WB_LO: begin
                rf_wr_en = 1'b1;
`ifdef ALU_HI_WB_EN
                state_n  = S_WB_HI;
`else
                done     = 1'b1;
                state_n  = S_IDLE;
`endif
            end
`ifdef ALU_HI_WB_EN
            S_WB_HI: begin
                // Address arithmetic is REG_AW wide, so rd = all-ones wraps to 0.
                rf_wr_en   = 1'b1;
                rf_wr_sel  = 1'b1;
                rf_wr_addr = rd_q + 1'b1;
                done       = 1'b1;
                state_n    = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed vector table, multi-cycle corner sequences, and
// randomized traffic checked every cycle against a phase-counter reference model.
module tb_alu_seq_ctrl;
    localparam int AW = 3;
    localparam int CW = 4;
`ifdef ALU_HI_WB_EN
    localparam int ITV = 5;
`else
    localparam int ITV = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
    logic          rf_rd_en, alu_op, res_load, rf_wr_en, rf_wr_sel, busy, done;
    logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
    logic [CW-1:0] ops_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ecnt  = 0;

    alu_seq_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .alu_op(alu_op), .res_load(res_load), .rf_wr_en(rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_sel(rf_wr_sel), .busy(busy), .done(done),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase counts cycles since acceptance; 0 means idle.
    int            m_ph  = 0;
    int            m_cnt = 0;
    logic          m_op  = 1'b0;
    logic [AW-1:0] m_ra  = '0, m_rb = '0, m_rd = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_cnt <= 0; m_op <= 1'b0; m_ra <= '0; m_rb <= '0; m_rd <= '0;
        end else if (m_ph == 0) begin
            if (cmd_valid) begin
                m_ph <= 1; m_op <= cmd_op; m_ra <= cmd_ra; m_rb <= cmd_rb; m_rd <= cmd_rd;
            end
        end else begin
            m_ph <= (m_ph == ITV - 1) ? 0 : m_ph + 1;
            if (m_ph == ITV - 1)
                m_cnt <= (m_cnt + 1) % (1 << CW);
        end
    end

    always @(negedge clk) begin
        logic [7:0] ectl, actl;
        int         ewa;
        ectl = {m_ph == 0, m_ph != 0, m_ph == 1, m_ph == 2, m_ph >= 3, m_ph == 4,
                m_ph == ITV - 1, m_op};
        actl = {cmd_ready, busy, rf_rd_en, res_load, rf_wr_en, rf_wr_sel, done, alu_op};
        chk("ctl", 32'(actl), 32'(ectl));
        chk("ops_done", 32'(ops_done), 32'(m_cnt));
        if (m_ph == 1)
            chk("rd_addrs", 32'({rf_rd_addr_a, rf_rd_addr_b}), 32'({m_ra, m_rb}));
        if (m_ph >= 3) begin
            ewa = (m_ph == 4) ? (int'(m_rd) + 1) % (1 << AW) : int'(m_rd);
            chk("wr_addr", 32'(rf_wr_addr), 32'(ewa));
        end
        chk("no_x", 32'($isunknown({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, ops_done})), 32'(0));
    end

    typedef struct {
        logic          op;
        logic [AW-1:0] ra, rb, rd, lo, hi;
    } vec_t;
    vec_t tbl[4];

    task automatic run_vec(input vec_t v, input int exp_cnt, output int waited);
        int acc;
        cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb; cmd_rd = v.rd; cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_bound", 32'(waited < 20), 32'(1));
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("v_read", 32'({rf_rd_en, rf_rd_addr_a, rf_rd_addr_b, alu_op}),
            32'({1'b1, v.ra, v.rb, v.op}));
        @(negedge clk);
        chk("v_exec", 32'({res_load, alu_op}), 32'({1'b1, v.op}));
        @(negedge clk);
        chk("v_lo", 32'({rf_wr_en, rf_wr_sel, rf_wr_addr}), 32'({2'b10, v.lo}));
        chk("v_lo_lat", 32'(cyc - acc), 32'(3));
`ifdef ALU_HI_WB_EN
        @(negedge clk);
        chk("v_hi", 32'({rf_wr_en, rf_wr_sel, rf_wr_addr, done, alu_op}),
            32'({2'b11, v.hi, 1'b1, v.op}));
        chk("v_hi_lat", 32'(cyc - acc), 32'(4));
`else
        chk("v_done_lo", 32'(done), 32'(1));
`endif
        @(negedge clk);
        chk("v_cnt", 32'(ops_done), 32'(exp_cnt));
        chk("v_ready", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, n, g, wr, prev_ready;
        int acc[3];
        tbl[0] = '{1'b0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
        tbl[1] = '{1'b1, 3'd4, 3'd5, 3'd7, 3'd7, 3'd0};
        tbl[2] = '{1'b0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd7};
        tbl[3] = '{1'b1, 3'd7, 3'd0, 3'd2, 3'd2, 3'd3};
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'({cmd_ready, busy, done, rf_rd_en, res_load, rf_wr_en, rf_wr_sel, alu_op}),
            32'(8'b1000_0000));
        chk("rst_addrs", 32'({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}), 32'(0));
        chk("rst_cnt", 32'(ops_done), 32'(0));

        // First command offered right as reset drops must be taken on the next edge.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ecnt = (ecnt + 1) % (1 << CW);
            run_vec(tbl[i], ecnt, w);
            if (i == 0)
                chk("first_accept", 32'(w), 32'(0));
        end

        // cmd_valid held high across three commands.
        cmd_op = 1'b1; cmd_ra = 3'd2; cmd_rb = 3'd3; cmd_rd = 3'd4; cmd_valid = 1'b1;
        n = 0; g = 0;
        while (n < 3 && g < 40) begin
            if (cmd_ready) begin
                acc[n] = cyc;
                n++;
            end
            @(negedge clk);
            g++;
        end
        cmd_valid = 1'b0;
        chk("b2b_count", 32'(n), 32'(3));
        chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'(ITV));
        chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'(ITV));
        repeat (ITV) @(negedge clk);
        ecnt = (ecnt + 3) % (1 << CW);
        chk("b2b_cnt", 32'(ops_done), 32'(ecnt));

        // Reset in EXEC aborts: no writeback, counter cleared, ready at once.
        cmd_op = 1'b0; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_rd = 3'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", 32'(res_load), 32'(1));
        #2 rst = 1'b1;
        #1 chk("abort_now", 32'({cmd_ready, busy, rf_wr_en, done}), 32'(4'b1000));
        @(negedge clk);
        rst = 1'b0;
        wr = 0;
        repeat (ITV) begin
            @(negedge clk);
            wr += int'(rf_wr_en);
        end
        chk("abort_no_wr", 32'(wr), 32'(0));
        chk("abort_cnt", 32'(ops_done), 32'(0));
        ecnt = 0;

        // 2^CNT_W operations: the last done wraps the counter to 0.
        for (int k = 0; k < (1 << CW); k++) begin
            ecnt = (ecnt + 1) % (1 << CW);
            run_vec(tbl[k % 4], ecnt, w);
        end
        chk("wrap_zero", 32'(ops_done), 32'(0));

        // Random traffic, including held-off and back-to-back offers.
        prev_ready = 0;
        for (int c = 0; c < 400; c++) begin
            if (cmd_valid && prev_ready != 0) begin
                if ($urandom_range(1) == 1) begin
                    cmd_op = 1'($urandom_range(1));
                    cmd_ra = AW'($urandom_range(7));
                    cmd_rb = AW'($urandom_range(7));
                    cmd_rd = AW'($urandom_range(7));
                end else
                    cmd_valid = 1'b0;
            end else if (!cmd_valid && $urandom_range(2) == 0) begin
                cmd_valid = 1'b1;
                cmd_op = 1'($urandom_range(1));
                cmd_ra = AW'($urandom_range(7));
                cmd_rb = AW'($urandom_range(7));
                cmd_rd = AW'($urandom_range(7));
            end
            prev_ready = int'(cmd_ready);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (ITV + 1) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
